// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } pll_state_e;

  // Width of the shared counter: enough to reach the largest terminal count.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned lock_timeout,
                                            input int unsigned stable_cycles);
    int unsigned m;
    m = hold_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer, asynchronous active-low reset to zero.
module sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// Sequences the PLL: hold in reset, wait for lock, qualify lock, run; retries and fault.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3,
  localparam int unsigned RETRY_W      = $clog2(MAX_RETRIES + 1)
) (
  input  logic               clk_in,
  input  logic               resetb_in,
  input  logic               lock_in,
  input  logic               soft_req,
  output logic               pll_resetb,
  output logic               reset_out,
  output logic               locked_ok,
  output logic               fault,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CntW-1:0]    HoldLast    = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]    TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0]    StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RetryMax    = RETRY_W'(MAX_RETRIES);

  pll_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic              lost_q, lost_d;
  logic              lock_s;

  sync2 #(
    .Width (1)
  ) u_lock_sync (
    .clk   (clk_in),
    .rst_n (resetb_in),
    .d     (lock_in),
    .q     (lock_s)
  );

  // Next-state logic; soft_req overrides everything, and every transition clears the counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retry_d   = retry_q;
    lost_d    = lost_q;
    retry_inc = retry_q + 1'b1;
    if (soft_req) begin
      state_d = StHold;
      cnt_d   = '0;
      retry_d = '0;
      lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_q == HoldLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == TimeoutLast) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RetryMax) ? StFault : StHold;
          end
        end
        StStable: begin
          if (!lock_s) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
        StRun: begin
          cnt_d = '0;
          if (!lock_s) begin
            state_d = StHold;
            lost_d  = 1'b1;
            retry_d = '0;
          end
        end
        StFault: begin
          cnt_d = '0;
        end
        default: begin
          state_d = StHold;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State register with outputs decoded from the next state so they move with it.
  always_ff @(posedge clk_in or negedge resetb_in) begin
    if (!resetb_in) begin
      state_q    <= StHold;
      cnt_q      <= '0;
      retry_q    <= '0;
      lost_q     <= 1'b0;
      pll_resetb <= 1'b0;
      reset_out  <= 1'b1;
      locked_ok  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      lost_q     <= lost_d;
      pll_resetb <= (state_d == StWaitLock) || (state_d == StStable) || (state_d == StRun);
      reset_out  <= (state_d != StRun);
      locked_ok  <= (state_d == StRun);
      fault      <= (state_d == StFault);
    end
  end

  assign lock_lost   = lost_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench for pll_reset_ctrl against a phase/timestamp reference model.
module tb_pll_reset_ctrl;

  localparam int H = 4;
  localparam int T = 16;
  localparam int S = 8;
  localparam int M = 3;
  localparam int RW = $clog2(M + 1);

  logic          clk_in;
  logic          resetb_in;
  logic          lock_in;
  logic          soft_req;
  logic          pll_resetb;
  logic          reset_out;
  logic          locked_ok;
  logic          fault;
  logic          lock_lost;
  logic [RW-1:0] retry_count;

  pll_reset_ctrl #(
    .HOLD_CYCLES   (H),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .MAX_RETRIES   (M)
  ) dut (
    .clk_in      (clk_in),
    .resetb_in   (resetb_in),
    .lock_in     (lock_in),
    .soft_req    (soft_req),
    .pll_resetb  (pll_resetb),
    .reset_out   (reset_out),
    .locked_ok   (locked_ok),
    .fault       (fault),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef enum int {PHold, PWait, PStable, PRun, PFault} phase_e;
  typedef struct {
    bit prb;
    bit rst;
    bit lok;
    bit flt;
    bit lost;
    int rc;
  } exp_t;

  exp_t   exp_q[$];
  phase_e ph = PHold;
  int     start = 0;
  int     edge_no = 0;
  int     retries = 0;
  bit     lost = 1'b0;
  bit     hist[$];
  bit     rst_pend = 1'b0;
  int     checks = 0;
  int     errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: actual %0d required %0d", nm, edge_no, act, req);
    end
  endfunction

  function automatic void model_reset();
    ph      = PHold;
    start   = edge_no;
    retries = 0;
    lost    = 1'b0;
    hist    = {1'b0, 1'b0};
  endfunction

  // Reference model: elapsed time in a phase is edges since the phase was entered.
  always @(posedge clk_in) begin
    exp_t   x;
    phase_e nph;
    bit     ls;
    int     e;
    if (rst_pend) begin
      model_reset();
      rst_pend = 1'b0;
    end
    edge_no++;
    if (!resetb_in) begin
      model_reset();
    end else begin
      // lock_in seen by the decision is the value sampled two edges earlier
      ls = hist.pop_front();
      hist.push_back(lock_in);
      e   = edge_no - start - 1;
      nph = ph;
      if (soft_req) begin
        nph     = PHold;
        retries = 0;
        lost    = 1'b0;
      end else begin
        case (ph)
          PHold:   if (e == H - 1) nph = PWait;
          PWait: begin
            if (ls) nph = PStable;
            else if (e == T - 1) begin
              retries++;
              nph = (retries == M) ? PFault : PHold;
            end
          end
          PStable: begin
            if (!ls) nph = PWait;
            else if (e == S - 1) nph = PRun;
          end
          PRun: begin
            if (!ls) begin
              nph     = PHold;
              lost    = 1'b1;
              retries = 0;
            end
          end
          default: nph = ph;
        endcase
      end
      if (soft_req || nph != ph) start = edge_no;
      ph = nph;
    end
    x.prb  = (ph == PWait) || (ph == PStable) || (ph == PRun);
    x.rst  = (ph != PRun);
    x.lok  = (ph == PRun);
    x.flt  = (ph == PFault);
    x.lost = lost;
    x.rc   = retries;
    exp_q.push_back(x);
  end

  // Monitor: one expected output set per clock, compared on the falling edge.
  always @(negedge clk_in) begin
    exp_t x;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      chk("pll_resetb", 32'(pll_resetb), 32'(x.prb));
      chk("reset_out", 32'(reset_out), 32'(x.rst));
      chk("locked_ok", 32'(locked_ok), 32'(x.lok));
      chk("fault", 32'(fault), 32'(x.flt));
      chk("lock_lost", 32'(lock_lost), 32'(x.lost));
      chk("retry_count", 32'(retry_count), 32'(x.rc));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic soft_pulse();
    @(negedge clk_in);
    soft_req = 1'b1;
    @(negedge clk_in);
    soft_req = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_resetb"}, 32'(pll_resetb), 32'd0);
    chk({tag, "_reset_out"}, 32'(reset_out), 32'd1);
    chk({tag, "_locked_ok"}, 32'(locked_ok), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
    chk({tag, "_retry_count"}, 32'(retry_count), 32'd0);
  endtask

  initial begin
    resetb_in = 1'b1;
    lock_in   = 1'b1;
    soft_req  = 1'b0;
    #1 resetb_in = 1'b0;
    #1 chk_reset_vals("por");
    cyc(3);
    #2 resetb_in = 1'b1;

    // Clean start, then soft restart out of RUN.
    cyc(20);
    soft_pulse();
    cyc(20);

    // Lock loss in RUN, re-lock keeps lock_lost set.
    lock_in = 1'b0;
    cyc(5);
    lock_in = 1'b1;
    cyc(20);

    // Loss again, then lock never returns: three timeouts into FAULT.
    lock_in = 1'b0;
    cyc(75);
    cyc(10);
    lock_in = 1'b1;
    soft_pulse();
    cyc(20);

    // Lock drops for 3 cycles mid-STABLE.
    soft_pulse();
    cyc(6);
    lock_in = 1'b0;
    cyc(3);
    lock_in = 1'b1;
    cyc(25);

    // soft_req lands on the same edge that first sees lock loss in RUN.
    @(negedge clk_in);
    lock_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    soft_req = 1'b1;
    @(negedge clk_in);
    soft_req = 1'b0;
    lock_in  = 1'b1;
    cyc(20);

    // Asynchronous reset pulse between edges while in STABLE.
    soft_pulse();
    cyc(7);
    #2 resetb_in = 1'b0;
    #1 chk_reset_vals("async");
    rst_pend = 1'b1;
    #1 resetb_in = 1'b1;
    cyc(20);

    // Randomized lock behaviour with occasional soft requests.
    for (int i = 0; i < 40; i++) begin
      lock_in = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 30)) begin
        @(negedge clk_in);
        soft_req = ($urandom_range(0, 39) == 0);
      end
    end
    soft_req = 1'b0;
    lock_in  = 1'b1;
    cyc(30);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
